// File: rtl/rtc_bus_ctrl_if.sv
// RTC multiplexed address/data bus pins.
// master = bus engine side, slave = RTC/pad side.
interface rtc_bus_ctrl_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;

  modport master (output cs_n, rd_n, wr_n, a_d, ad_out, ad_oe, input  ad_in);
  modport slave  (input  cs_n, rd_n, wr_n, a_d, ad_out, ad_oe, output ad_in);
endinterface

// File: rtl/rtc_bus_ctrl.sv
// Physical bus engine for the external RTC: one address phase plus one data phase per request.
// Optional macro RTC_AD_SYNC_EN adds a 2-flop ad_in synchronizer and stretches the read strobe by 2 cycles.
//
// state      | meaning
// IDLE       | waiting for escritura/lectura, latches request
// A_SETUP    | address driven, cs_n low, a_d=0
// A_STROBE   | address driven, wr_n low
// A_HOLD     | address held, wr_n high
// GAP        | bus released, cs_n high
// D_SETUP    | data phase, write data driven on WR
// D_STROBE   | wr_n (WR) or rd_n (RD) low, RD capture on last cycle
// D_HOLD     | strobes high, cs_n still low
// DONE       | fin pulse, optional register-file write
// COOL       | requests ignored for T_REARM cycles
module rtc_bus_ctrl #(
  parameter int T_PH    = 4,
  parameter int T_REARM = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  escritura,
  input  logic                  lectura,
  input  logic [7:0]            dir,
  input  logic [7:0]            dato,
  input  logic [3:0]            dir_reg,
  input  logic                  write,
  output logic                  fin,
  output logic                  busy,
  rtc_bus_ctrl_if.master        bus,
  output logic                  reg_we,
  output logic [3:0]            reg_addr,
  output logic [7:0]            reg_data
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_A_SETUP  = 4'd1;
  localparam logic [3:0] S_A_STROBE = 4'd2;
  localparam logic [3:0] S_A_HOLD   = 4'd3;
  localparam logic [3:0] S_GAP      = 4'd4;
  localparam logic [3:0] S_D_SETUP  = 4'd5;
  localparam logic [3:0] S_D_STROBE = 4'd6;
  localparam logic [3:0] S_D_HOLD   = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;
  localparam logic [3:0] S_COOL     = 4'd9;

  localparam logic [7:0] PH_LAST    = 8'(T_PH - 1);
  localparam logic [7:0] REARM_LAST = 8'(T_REARM - 1);
`ifdef RTC_AD_SYNC_EN
  localparam logic [7:0] RD_STB_LAST = 8'(T_PH + 1);
`else
  localparam logic [7:0] RD_STB_LAST = 8'(T_PH - 1);
`endif

  logic [3:0] state, state_nx;
  logic [7:0] cnt;
  logic [7:0] seg_last;
  logic       seg_done;
  logic       accept;

  logic       op_rd, op_rd_nx;
  logic [7:0] dir_q, dir_nx;
  logic [7:0] dato_q, dato_nx;
  logic [3:0] dir_reg_q;
  logic       write_q, write_nx;

  logic       cs_n_nx, rd_n_nx, wr_n_nx, a_d_nx, ad_oe_nx;
  logic [7:0] ad_out_nx;
  logic [7:0] ad_samp;

`ifdef RTC_AD_SYNC_EN
  logic [7:0] ad_s1, ad_s2;
  always_ff @(posedge clk) begin
    if (reset) begin
      ad_s1 <= 8'h00;
      ad_s2 <= 8'h00;
    end else begin
      ad_s1 <= bus.ad_in;
      ad_s2 <= ad_s1;
    end
  end
  assign ad_samp = ad_s2;
`else
  assign ad_samp = bus.ad_in;
`endif

  assign accept = (state == S_IDLE) && (escritura || lectura);

  always_comb begin
    seg_last = PH_LAST;
    unique case (state)
      S_DONE:     seg_last = 8'd0;
      S_COOL:     seg_last = REARM_LAST;
      S_D_STROBE: seg_last = op_rd ? RD_STB_LAST : PH_LAST;
      default:    seg_last = PH_LAST;
    endcase
  end

  assign seg_done = (cnt == seg_last);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:     if (accept)   state_nx = S_A_SETUP;
      S_A_SETUP:  if (seg_done) state_nx = S_A_STROBE;
      S_A_STROBE: if (seg_done) state_nx = S_A_HOLD;
      S_A_HOLD:   if (seg_done) state_nx = S_GAP;
      S_GAP:      if (seg_done) state_nx = S_D_SETUP;
      S_D_SETUP:  if (seg_done) state_nx = S_D_STROBE;
      S_D_STROBE: if (seg_done) state_nx = S_D_HOLD;
      S_D_HOLD:   if (seg_done) state_nx = S_DONE;
      S_DONE:                   state_nx = S_COOL;
      S_COOL:     if (seg_done) state_nx = S_IDLE;
      default:                  state_nx = S_IDLE;
    endcase
  end

  // Output registers decode the next state, so pins line up with the state they belong to.
  assign op_rd_nx = accept ? !escritura : op_rd;
  assign dir_nx   = accept ? dir        : dir_q;
  assign dato_nx  = accept ? dato       : dato_q;
  assign write_nx = accept ? write      : write_q;

  always_comb begin
    cs_n_nx   = 1'b1;
    rd_n_nx   = 1'b1;
    wr_n_nx   = 1'b1;
    a_d_nx    = 1'b1;
    ad_oe_nx  = 1'b0;
    ad_out_nx = 8'h00;
    unique case (state_nx)
      S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
        cs_n_nx   = 1'b0;
        a_d_nx    = 1'b0;
        ad_oe_nx  = 1'b1;
        ad_out_nx = dir_nx;
        if (state_nx == S_A_STROBE) wr_n_nx = 1'b0;
      end
      S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
        cs_n_nx = 1'b0;
        if (!op_rd_nx) begin
          ad_oe_nx  = 1'b1;
          ad_out_nx = dato_nx;
        end
        if (state_nx == S_D_STROBE) begin
          if (op_rd_nx) rd_n_nx = 1'b0;
          else          wr_n_nx = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      op_rd     <= 1'b0;
      dir_q     <= 8'h00;
      dato_q    <= 8'h00;
      dir_reg_q <= 4'h0;
      write_q   <= 1'b0;
      fin       <= 1'b0;
      busy      <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= 4'h0;
      reg_data  <= 8'h00;
      bus.cs_n  <= 1'b1;
      bus.rd_n  <= 1'b1;
      bus.wr_n  <= 1'b1;
      bus.a_d   <= 1'b1;
      bus.ad_oe <= 1'b0;
      bus.ad_out <= 8'h00;
    end else begin
      state <= state_nx;
      if ((state_nx != state) || (state_nx == S_IDLE)) cnt <= 8'd0;
      else                                             cnt <= cnt + 8'd1;
      if (accept) begin
        op_rd     <= op_rd_nx;
        dir_q     <= dir_nx;
        dato_q    <= dato_nx;
        dir_reg_q <= dir_reg;
        write_q   <= write_nx;
      end
      if ((state == S_D_STROBE) && seg_done && op_rd) reg_data <= ad_samp;
      if (state_nx == S_DONE) reg_addr <= dir_reg_q;
      fin        <= (state_nx == S_DONE);
      reg_we     <= (state_nx == S_DONE) && op_rd && write_q;
      busy       <= (state_nx != S_IDLE);
      bus.cs_n   <= cs_n_nx;
      bus.rd_n   <= rd_n_nx;
      bus.wr_n   <= wr_n_nx;
      bus.a_d    <= a_d_nx;
      bus.ad_oe  <= ad_oe_nx;
      bus.ad_out <= ad_out_nx;
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl (T_PH=4, T_REARM=3, default build); cycle 0 = cycle the request is presented.
module tb_rtc_bus_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       escritura, lectura, write;
  logic [7:0] dir, dato;
  logic [3:0] dir_reg;
  logic       fin, busy, reg_we;
  logic [3:0] reg_addr;
  logic [7:0] reg_data;

  rtc_bus_ctrl_if bus ();

  rtc_bus_ctrl #(.T_PH(4), .T_REARM(3)) dut (
    .clk(clk), .reset(reset), .escritura(escritura), .lectura(lectura),
    .dir(dir), .dato(dato), .dir_reg(dir_reg), .write(write),
    .fin(fin), .busy(busy), .bus(bus),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data)
  );

  always #5 clk = ~clk;

  localparam int N = 80;
  logic       o_fin[N], o_busy[N], o_cs[N], o_rd[N], o_wr[N], o_ad[N], o_oe[N], o_we[N];
  logic [7:0] o_out[N], o_rdat[N];
  logic [3:0] o_radr[N];

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rec(input int c);
    o_fin[c] = fin;        o_busy[c] = busy;      o_cs[c] = bus.cs_n;
    o_rd[c]  = bus.rd_n;   o_wr[c]   = bus.wr_n;  o_ad[c] = bus.a_d;
    o_oe[c]  = bus.ad_oe;  o_out[c]  = bus.ad_out; o_we[c] = reg_we;
    o_radr[c] = reg_addr;  o_rdat[c] = reg_data;
  endtask

  // Request presented in cycle 0; cycles 1..n recorded. RTC model drives 8'h45 while rd_n is low.
  task automatic run(input int n, input int drop_at, input int chg_at, input logic [7:0] dir2, input int rst_at);
    for (int c = 1; c <= n; c++) begin
      step();
      rec(c);
      bus.ad_in = (o_rd[c] == 1'b0) ? 8'h45 : 8'hAA;
      if (c == drop_at) begin escritura = 1'b0; lectura = 1'b0; end
      if (c == chg_at) dir = dir2;
      reset = (c == rst_at);
    end
  endtask

  function automatic int cnt_low_rd(input int a, input int b);
    int k = 0;
    for (int i = a; i <= b; i++) if (o_rd[i] == 1'b0) k++;
    return k;
  endfunction
  function automatic int cnt_low_wr(input int a, input int b);
    int k = 0;
    for (int i = a; i <= b; i++) if (o_wr[i] == 1'b0) k++;
    return k;
  endfunction
  function automatic int cnt_fin(input int a, input int b);
    int k = 0;
    for (int i = a; i <= b; i++) if (o_fin[i]) k++;
    return k;
  endfunction
  function automatic int cnt_we(input int a, input int b);
    int k = 0;
    for (int i = a; i <= b; i++) if (o_we[i]) k++;
    return k;
  endfunction

  initial begin
    reset = 1'b1; escritura = 1'b0; lectura = 1'b0; write = 1'b0;
    dir = 8'h00; dato = 8'h00; dir_reg = 4'h0; bus.ad_in = 8'hAA;
    repeat (3) step();
    reset = 1'b0;

    // Reset values, then idle
    step();
    chk("rst_fin", fin, 1'b0);          chk("rst_busy", busy, 1'b0);
    chk("rst_cs_n", bus.cs_n, 1'b1);    chk("rst_rd_n", bus.rd_n, 1'b1);
    chk("rst_wr_n", bus.wr_n, 1'b1);    chk("rst_a_d", bus.a_d, 1'b1);
    chk("rst_ad_out", bus.ad_out, 8'h00); chk("rst_ad_oe", bus.ad_oe, 1'b0);
    chk("rst_reg_we", reg_we, 1'b0);    chk("rst_reg_addr", reg_addr, 4'h0);
    chk("rst_reg_data", reg_data, 8'h00);
    run(10, -1, -1, 8'h00, -1);
    chk("idle_fin_cnt", cnt_fin(1, 10), 0);
    chk("idle_busy", o_busy[10], 1'b0);

    // Write F0 <- FF
    dir = 8'hF0; dato = 8'hFF; escritura = 1'b1;
    run(40, 1, -1, 8'h00, -1);
    chk("wr_busy_c1", o_busy[1], 1'b1);
    chk("wr_addr_strobe_cnt", cnt_low_wr(1, 12), 4);
    chk("wr_addr_wr_n_c5", o_wr[5], 1'b0);
    chk("wr_addr_a_d_c5", o_ad[5], 1'b0);
    chk("wr_addr_out_c8", o_out[8], 8'hF0);
    chk("wr_gap_cs_n_c13", o_cs[13], 1'b1);
    chk("wr_data_strobe_cnt", cnt_low_wr(13, 40), 4);
    chk("wr_data_wr_n_c21", o_wr[21], 1'b0);
    chk("wr_data_a_d_c24", o_ad[24], 1'b1);
    chk("wr_data_out_c24", o_out[24], 8'hFF);
    chk("wr_data_oe_c24", o_oe[24], 1'b1);
    chk("wr_fin_c28", o_fin[28], 1'b0);
    chk("wr_fin_c29", o_fin[29], 1'b1);
    chk("wr_fin_cnt", cnt_fin(1, 40), 1);
    chk("wr_reg_we_cnt", cnt_we(1, 40), 0);
    chk("wr_busy_c32", o_busy[32], 1'b1);
    chk("wr_busy_c33", o_busy[33], 1'b0);

    // Read 21 -> reg 1
    dir = 8'h21; dir_reg = 4'h1; write = 1'b1; lectura = 1'b1;
    run(40, 1, -1, 8'h00, -1);
    chk("rd_rd_n_cnt", cnt_low_rd(1, 40), 4);
    chk("rd_rd_n_c21", o_rd[21], 1'b0);
    chk("rd_rd_n_c24", o_rd[24], 1'b0);
    chk("rd_oe_c22", o_oe[22], 1'b0);
    chk("rd_addr_out_c6", o_out[6], 8'h21);
    chk("rd_wr_n_cnt", cnt_low_wr(1, 40), 4);
    chk("rd_fin_c29", o_fin[29], 1'b1);
    chk("rd_reg_we_c29", o_we[29], 1'b1);
    chk("rd_reg_addr_c29", o_radr[29], 4'h1);
    chk("rd_reg_data_c29", o_rdat[29], 8'h45);
    chk("rd_reg_we_cnt", cnt_we(1, 40), 1);

    // Back-to-back reads, dir changes two cycles after first fin
    dir = 8'h21; write = 1'b0; lectura = 1'b1;
    run(75, 34, 31, 8'h22, -1);
    chk("b2b_out_c5", o_out[5], 8'h21);
    chk("b2b_fin_c29", o_fin[29], 1'b1);
    chk("b2b_busy_c33", o_busy[33], 1'b0);
    chk("b2b_out_c38", o_out[38], 8'h22);
    chk("b2b_fin_c62", o_fin[62], 1'b1);
    chk("b2b_fin_cnt", cnt_fin(1, 75), 2);
    chk("b2b_reg_we_cnt", cnt_we(1, 75), 0);

    // Both requests: write wins
    dir = 8'h30; dato = 8'h5A; escritura = 1'b1; lectura = 1'b1;
    run(40, 1, -1, 8'h00, -1);
    chk("both_rd_n_cnt", cnt_low_rd(1, 40), 0);
    chk("both_wr_data_c22", o_out[22], 8'h5A);
    chk("both_fin_c29", o_fin[29], 1'b1);

    // Reset during read data strobe
    dir = 8'h21; dir_reg = 4'h3; write = 1'b1; lectura = 1'b1;
    run(40, 1, -1, 8'h00, 22);
    chk("abort_rd_n_c22", o_rd[22], 1'b0);
    chk("abort_cs_n_c23", o_cs[23], 1'b1);
    chk("abort_rd_n_c23", o_rd[23], 1'b1);
    chk("abort_busy_c23", o_busy[23], 1'b0);
    chk("abort_fin_cnt", cnt_fin(1, 40), 0);
    chk("abort_reg_we_cnt", cnt_we(1, 40), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rtc_bus_ctrl.md
Name: rtc_bus_ctrl

Overview:
- Physical bus engine for the external RTC, which uses a multiplexed 8-bit address/data bus.
- Sits directly downstream of the RTC register-walk sequencer. Consumes that block's 8-bit address, write data, write/read requests and register index.
- For each request, runs one address-phase plus data-phase cycle on the RTC pins, then returns a one-cycle `fin` pulse.
- On reads, pushes the sampled byte into the time register file at the given index.

Parameters:
- T_PH, 4, clk cycles per bus phase segment (min 1).
- T_REARM, 3, cooldown cycles after `fin` before a new request is accepted (min 2). Covers the sequencer's 2-cycle output update lag.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- escritura  in  1  write request (level)
- lectura  in  1  read request (level)
- dir  in  8  RTC register address
- dato  in  8  write data
- dir_reg  in  4  destination register-file index for read data
- write  in  1  store-enable qualifier for read data
- fin  out  1  one-cycle done pulse to sequencer
- busy  out  1  high whenever state != IDLE
- cs_n  out  1  RTC chip select, active-low
- rd_n  out  1  RTC read strobe, active-low
- wr_n  out  1  RTC write strobe, active-low
- a_d  out  1  0 = address phase, 1 = data phase
- ad_out  out  8  bus drive value
- ad_oe  out  1  bus output enable (top-level tristate)
- ad_in  in  8  bus input value
- reg_we  out  1  register-file write strobe
- reg_addr  out  4  register-file index
- reg_data  out  8  register-file data

Behaviour:
- Reset values: fin=0, busy=0, cs_n=1, rd_n=1, wr_n=1, a_d=1, ad_out=0, ad_oe=0, reg_we=0, reg_addr=0, reg_data=0. State=IDLE, phase counter=0.
- Reset mid-transaction: abort on the next edge and return to the reset values. No `fin` is produced.
- All outputs are registered. The bus pins are a Moore decode of the registered state.
- States and transitions. Each timed state lasts exactly T_PH cycles, counted by a phase counter that clears on every state entry.
  - IDLE: if escritura=1 or lectura=1, latch dir, dato, dir_reg, write and op. op=WR if escritura=1, else RD; escritura wins if both are high. Go to A_SETUP.
  - A_SETUP: cs_n=0, a_d=0, ad_oe=1, ad_out=latched dir.
  - A_STROBE: as A_SETUP, plus wr_n=0.
  - A_HOLD: wr_n=1, address still driven.
  - GAP: cs_n=1, a_d=1, ad_oe=0.
  - D_SETUP: cs_n=0, a_d=1. For WR: ad_oe=1, ad_out=latched dato. For RD: ad_oe=0.
  - D_STROBE: WR drives wr_n=0; RD drives rd_n=0. For RD, ad_in is captured into reg_data on the last cycle of the state.
  - D_HOLD: strobes high, cs_n=0. WR keeps driving the bus.
  - DONE (1 cycle): fin=1, cs_n=1, ad_oe=0. reg_we=1 only if op=RD and latched write=1; reg_addr=latched dir_reg.
  - COOL (T_REARM cycles): requests ignored. Then IDLE.
- Latency: with a request sampled in IDLE at cycle 0, fin is high at cycle 7*T_PH+1.
- Next possible acceptance: IDLE at cycle 7*T_PH+2+T_REARM.
- Inputs that change after latch have no effect on the current transaction.
- wr_n and rd_n are never low at the same time. No strobe is ever low while cs_n=1.
- reg_we and fin are single-cycle pulses and never repeat without a new request.

Optional Feature:
- Macro: RTC_AD_SYNC_EN.
- Defined:
  - ad_in passes through a 2-flop synchronizer.
  - D_STROBE lasts T_PH+2 cycles for RD only; capture is still on its last cycle.
  - RD fin latency becomes 7*T_PH+3.
- Undefined: ad_in is sampled directly; timing is as specified above.

Test Plan:
- Reset then idle, with T_PH=4 and T_REARM=3 → all reset values hold; busy=0, fin never asserts.
- escritura=1, dir=8'hF0, dato=8'hFF → address 8'hF0 driven during wr_n=0 (4 cycles, a_d=0); 8'hFF driven during second wr_n=0 (a_d=1); fin at cycle 29; reg_we=0.
- lectura=1, write=1, dir=8'h21, dir_reg=4'h1, ad_in=8'h45 during D_STROBE → rd_n low 4 cycles; fin at cycle 29 with reg_we=1, reg_addr=4'h1, reg_data=8'h45 in the same cycle.
- Sequencer-style back-to-back reads: lectura held high, dir changes 8'h21→8'h22 two cycles after fin → second transaction uses 8'h22; exactly one fin per transaction; no stale repeat of 8'h21.
- escritura=1 and lectura=1 together → WR transaction; rd_n stays 1 throughout.
- reset pulsed in D_STROBE of a read → next cycle cs_n=1, rd_n=1, busy=0; no fin, no reg_we.
